tacky_fetch: RTL and testbench

Instruction fetch stage for the Tacky multi-cycle processor. Reads instruction words from instruction memory ahead of the decoder and buffers them in a small FIFO. Presents them to the decode/execute FSM with a valid/ready handshake, tagged with their PC. Handles control-flow redirects from execute by flushing the buffer, and discards any read still in flight.

---
 rtl/tacky_pkg.sv | 34 +++
 rtl/tacky_fetch_fifo.sv | 80 ++++++++
 rtl/tacky_fetch.sv | 191 +++++++++++++++++++
 tb/tb_tacky_fetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tacky_pkg.sv
// tacky_pkg: shared definitions for the Tacky processor front end.
//   WORD            instruction word width
//   OPC_HI/OPC_LO   opcode field position inside a word
//   OP_PRE          opcode of the "pre" prefix instruction
//   PFX_W           width of the prefix payload (word bits [7:0])
//   fetch_state_e   fetch stage state encoding (FETCH / HALTED)
package tacky_pkg;

  localparam int WORD   = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;
  localparam int PFX_W  = 8;

  localparam logic [OPC_W-1:0] OP_PRE = 5'b10001;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [WORD-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [PFX_W-1:0] prefix_of(input logic [WORD-1:0] w);
    return w[PFX_W-1:0];
  endfunction

  function automatic logic is_pre(input logic [WORD-1:0] w);
    return (opcode_of(w) == OP_PRE);
  endfunction

endpackage

// File: rtl/tacky_fetch_fifo.sv
// tacky_fetch_fifo: small synchronous FIFO with flush, occupancy count and
// a head word read straight out of the storage registers.
//   clk, reset   clock, synchronous active-high reset (clears storage too)
//   push/push_data  write an entry (ignored when full)
//   pop          remove the head (ignored when empty)
//   flush        drop every entry; wins over push/pop in the same cycle
//   head         entry at the head of the queue
//   valid        registered non-empty flag
//   count        current occupancy, 0..DEPTH
module tacky_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [PW:0]   count_nxt_s;
  logic          valid_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against full/empty and compute the next occupancy.
  always_comb begin
    do_push_s   = push && (count_r != (PW+1)'(DEPTH));
    do_pop_s    = pop && valid_r;
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + (PW+1)'(1);
      2'b01:   count_nxt_s = count_r - (PW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      valid_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != (PW+1)'(0));
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/tacky_fetch.sv
// tacky_fetch: instruction fetch stage of the Tacky multi-cycle processor.
// Reads instruction memory ahead of decode into a DEPTH-entry FIFO and hands
// words to decode with a valid/ready handshake, tagged with their PC.
//   clk, reset              clock, synchronous active-high reset
//   imem_rd, imem_addr      read strobe/address; data returns next cycle
//   imem_data               returned instruction word
//   redirect, redirect_pc   taken jump/branch from execute (one-cycle pulse)
//   halt_req                stop issuing reads (stage parks in HALTED)
//   ir_valid, ir, ir_pc     head entry towards decode
//   ir_pre_valid, ir_pre    fused prefix carried by the head entry
//   ir_ready                decode accepts the head this cycle
// Build option: define TACKY_FETCH_PRE_FUSE_EN to fold "pre" words into the
// following instruction; otherwise they are delivered as plain words and the
// prefix outputs stay 0.
module tacky_fetch
  import tacky_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_rd,
  output logic [AW-1:0]    imem_addr,
  input  logic [WORD-1:0]  imem_data,
  input  logic             redirect,
  input  logic [AW-1:0]    redirect_pc,
  input  logic             halt_req,
  output logic             ir_valid,
  output logic [WORD-1:0]  ir,
  output logic [AW-1:0]    ir_pc,
  output logic             ir_pre_valid,
  output logic [PFX_W-1:0] ir_pre,
  input  logic             ir_ready
);

  localparam int EW = WORD + AW + 1 + PFX_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [AW-1:0]    fetch_pc_r;
  logic             inflight_r;
  logic [AW-1:0]    inflight_pc_r;
  logic             kill_r;
  logic             issue_s;
  logic             pop_s;
  logic             ret_ok_s;
  logic             push_s;
  logic             push_pre_valid_s;
  logic [PFX_W-1:0] push_pre_s;
  logic [EW-1:0]    push_data_s;
  logic [EW-1:0]    head_s;
  logic [CW-1:0]    count_s;
  logic             fifo_valid_s;
  logic [CW:0]      need_s;
  logic             room_s;

  assign pop_s = fifo_valid_s && ir_ready;

  // Credit check: the slot a new read will need next cycle must exist after
  // this cycle's return (inflight) and this cycle's pop are accounted for.
  always_comb begin
    need_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    room_s = (need_s < (CW+1)'(DEPTH));
  end

  // Next-state and issue decision.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      FETCH: begin
        if (halt_req) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = FETCH;
        end
        if (!reset && !halt_req && !redirect && room_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
        issue_s     = 1'b0;
      end
      default: begin
        state_nxt_s = FETCH;
        issue_s     = 1'b0;
      end
    endcase
  end

  assign imem_rd   = issue_s;
  assign imem_addr = issue_s ? fetch_pc_r : {AW{1'b0}};

  // State, fetch PC and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FETCH;
      fetch_pc_r    <= {AW{1'b0}};
      inflight_r    <= 1'b0;
      inflight_pc_r <= {AW{1'b0}};
      kill_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (redirect) begin
        fetch_pc_r <= redirect_pc;
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + AW'(1);
      end
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
      end
      // Reads are never issued in a redirect cycle, so this only guards the
      // one return slot following a redirect.
      kill_r <= redirect && inflight_r;
    end
  end

  // A returning word is usable unless it belongs to the pre-redirect stream.
  assign ret_ok_s = inflight_r && !kill_r && !redirect;

`ifdef TACKY_FETCH_PRE_FUSE_EN
  logic             pre_pending_r;
  logic [PFX_W-1:0] pre_reg_r;
  logic             ret_is_pre_s;

  assign ret_is_pre_s = is_pre(imem_data);

  // Prefix words are absorbed; the next real instruction carries the prefix.
  always_comb begin
    push_s           = ret_ok_s && !ret_is_pre_s;
    push_pre_valid_s = pre_pending_r;
    if (pre_pending_r) begin
      push_pre_s = pre_reg_r;
    end else begin
      push_pre_s = {PFX_W{1'b0}};
    end
  end

  // Pending prefix register; a newer prefix overwrites an older one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_pending_r <= 1'b0;
      pre_reg_r     <= {PFX_W{1'b0}};
    end else if (redirect) begin
      pre_pending_r <= 1'b0;
    end else if (ret_ok_s && ret_is_pre_s) begin
      pre_pending_r <= 1'b1;
      pre_reg_r     <= prefix_of(imem_data);
    end else if (push_s) begin
      pre_pending_r <= 1'b0;
    end
  end
`else
  // Without fusion every returned word is an ordinary instruction.
  always_comb begin
    push_s           = ret_ok_s;
    push_pre_valid_s = 1'b0;
    push_pre_s       = {PFX_W{1'b0}};
  end
`endif

  assign push_data_s = {imem_data, inflight_pc_r, push_pre_valid_s, push_pre_s};

  tacky_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (redirect),
    .head      (head_s),
    .valid     (fifo_valid_s),
    .count     (count_s)
  );

  assign ir_valid     = fifo_valid_s;
  assign ir           = head_s[EW-1 -: WORD];
  assign ir_pc        = head_s[PFX_W+1 +: AW];
  assign ir_pre_valid = head_s[PFX_W];
  assign ir_pre       = head_s[PFX_W-1:0];

endmodule

// File: tb/tb_tacky_fetch.sv
// Bench for tacky_fetch: an instruction memory model, a scoreboard loaded
// with the instruction stream expected from each (re)start address, a
// monitor that checks every handshake, plus directed timing checks.
module tb_tacky_fetch;

  localparam int DEPTH      = 4;
  localparam int AW         = 16;
  localparam int STREAM_LEN = 512;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] pc;
    logic        pv;
    logic [7:0]  pre;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_pre_valid;
  logic [7:0]  ir_pre;
  logic        ir_ready;

  logic [15:0] imem [65536];
  exp_t        sb [$];
  exp_t        mon_e;
  logic [15:0] mem_nxt;
  int          checks   = 0;
  int          errors   = 0;
  int          hs_count = 0;
  int          rd_count = 0;

  tacky_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .ir_valid     (ir_valid),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_pre_valid (ir_pre_valid),
    .ir_pre       (ir_pre),
    .ir_ready     (ir_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected delivery stream starting at a (re)start address.
  task automatic load_stream(input logic [15:0] start);
    logic [15:0] pc;
    logic [15:0] w;
    logic        pend;
    logic [7:0]  pre;
    int          guard;
    sb.delete();
    pc = start; pend = 1'b0; pre = 8'h00; guard = 0;
    while (sb.size() < STREAM_LEN && guard < 4*STREAM_LEN) begin
      w = imem[pc];
`ifdef TACKY_FETCH_PRE_FUSE_EN
      if (w[15:11] == 5'b10001) begin
        pend = 1'b1;
        pre  = w[7:0];
      end else begin
        sb.push_back('{w: w, pc: pc, pv: pend, pre: pre});
        pend = 1'b0;
        pre  = 8'h00;
      end
`else
      sb.push_back('{w: w, pc: pc, pv: 1'b0, pre: 8'h00});
`endif
      pc = pc + 16'd1;
      guard++;
    end
  endtask

  // Memory: capture the request mid-cycle, present data the next cycle.
  always begin
    @(negedge clk);
    mem_nxt = imem_rd ? imem[imem_addr] : 16'($urandom);
    @(posedge clk);
    #1;
    imem_data = mem_nxt;
  end

  // Monitor: count read strobes and check every accepted head entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_rd) rd_count++;
      if (ir_valid && ir_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual ir=%h ir_pc=%h expected no entry", ir, ir_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_entry", 64'({ir, ir_pc, ir_pre_valid, ir_pre}), 64'(mon_e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset; afterwards we sit in cycle 0.
  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; halt_req = 1'b0;
    step();
    reset = 1'b0;
    load_stream(16'h0000);
  endtask

  // Redirect at cycle t and check the t..t+3 timing.
  task automatic redirect_to(input logic [15:0] tgt, input string tag);
    redirect = 1'b1; redirect_pc = tgt;
    #3;
    chk({tag, "_rd_at_t"}, 64'(imem_rd), 64'(0));
    step();
    redirect = 1'b0;
    load_stream(tgt);
    #3;
    chk({tag, "_rd_t1"}, 64'(imem_rd), 64'(1));
    chk({tag, "_addr_t1"}, 64'(imem_addr), 64'(tgt));
    chk({tag, "_valid_t1"}, 64'(ir_valid), 64'(0));
    step(); #3;
    chk({tag, "_valid_t2"}, 64'(ir_valid), 64'(0));
    step(); #3;
    chk({tag, "_valid_t3"}, 64'(ir_valid), 64'(1));
    chk({tag, "_pc_t3"}, 64'(ir_pc), 64'(tgt));
  endtask

  initial begin
    int hs0;
    int rd0;
    int since;
    logic pend_load;
    logic [15:0] pend_pc;
    int r;

    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    halt_req = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 65536; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h0801; imem[1] = 16'h4002; imem[2] = 16'h5003; imem[3] = 16'h6004;
    imem[4] = 16'h7005; imem[5] = 16'h0806; imem[6] = 16'h0807; imem[7] = 16'h0808;
    imem[16'h0100] = 16'h3100;
    imem[16'hFFFE] = 16'h1234; imem[16'hFFFF] = 16'h2345;
    step(); step();

    // Start-up latency, reset values and streaming throughput.
    do_reset();
    #3;
    chk("rst_ir_valid", 64'(ir_valid), 64'(0));
    chk("rst_ir", 64'(ir), 64'(0));
    chk("rst_ir_pc", 64'(ir_pc), 64'(0));
    chk("rst_pre_valid", 64'(ir_pre_valid), 64'(0));
    chk("rst_pre", 64'(ir_pre), 64'(0));
    chk("c0_imem_rd", 64'(imem_rd), 64'(1));
    chk("c0_imem_addr", 64'(imem_addr), 64'(0));
    step(); #3;
    chk("c1_ir_valid", 64'(ir_valid), 64'(0));
    step(); #3;
    chk("c2_ir_valid", 64'(ir_valid), 64'(1));
    chk("c2_ir", 64'(ir), 64'(16'h0801));
    hs0 = hs_count;
    repeat (6) step();
    #3;
    chk("stream_rate", 64'(hs_count - hs0), 64'(6));

    // Decoder stalled: only DEPTH reads may be outstanding.
    ir_ready = 1'b0;
    do_reset();
    rd0 = rd_count;
    repeat (10) step();
    #3;
    chk("stall_reads", 64'(rd_count - rd0), 64'(DEPTH));
    chk("stall_rd_low", 64'(imem_rd), 64'(0));
    chk("stall_valid", 64'(ir_valid), 64'(1));
    step();
    ir_ready = 1'b1;
    hs0 = hs_count;
    #3;
    chk("unstall_rd", 64'(imem_rd), 64'(1));
    chk("unstall_addr", 64'(imem_addr), 64'(4));
    repeat (8) step();
    #3;
    chk("unstall_rate", 64'(hs_count - hs0), 64'(8));

    // Redirect while the read of address 5 is in flight.
    do_reset();
    repeat (6) step();
    redirect_to(16'h0100, "redir");
    repeat (6) step();

    // PC wrap-around.
    redirect_to(16'hFFFE, "wrap");
    hs0 = hs_count;
    repeat (5) step();
    #3;
    chk("wrap_rate", 64'(hs_count - hs0), 64'(5));

    // Halt at cycle 5: in-flight word lands, buffer drains, no more reads.
    do_reset();
    hs0 = hs_count;
    rd0 = rd_count;
    repeat (5) step();
    halt_req = 1'b1;
    #3;
    chk("halt_rd_c5", 64'(imem_rd), 64'(0));
    chk("halt_reads_before", 64'(rd_count - rd0), 64'(5));
    step();
    halt_req = 1'b0;
    repeat (10) step();
    #3;
    chk("halt_no_reads", 64'(rd_count - rd0), 64'(5));
    chk("halt_drained", 64'(hs_count - hs0), 64'(5));
    chk("halt_valid_low", 64'(ir_valid), 64'(0));
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    repeat (5) step();
    #3;
    chk("halt_redirect_no_rd", 64'(rd_count - rd0), 64'(5));
    chk("halt_redirect_valid", 64'(ir_valid), 64'(0));

    // Prefix word at address 0.
    imem[0] = 16'h88AB;
    do_reset();
    step(); step(); #3;
`ifdef TACKY_FETCH_PRE_FUSE_EN
    chk("pre_c2_valid", 64'(ir_valid), 64'(0));
    step(); #3;
    chk("pre_c3_ir", 64'(ir), 64'(16'h4002));
    chk("pre_c3_pc", 64'(ir_pc), 64'(1));
    chk("pre_c3_pv", 64'(ir_pre_valid), 64'(1));
    chk("pre_c3_pre", 64'(ir_pre), 64'(8'hAB));
`else
    chk("pre_c2_ir", 64'(ir), 64'(16'h88AB));
    chk("pre_c2_pv", 64'(ir_pre_valid), 64'(0));
    step(); #3;
    chk("pre_c3_ir", 64'(ir), 64'(16'h4002));
    chk("pre_c3_pc", 64'(ir_pc), 64'(1));
`endif
    repeat (4) step();

    // Random backpressure, redirects and occasional resets.
    do_reset();
    hs0 = hs_count;
    since = 0; pend_load = 1'b0; pend_pc = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (pend_load) begin
        load_stream(pend_pc);
        pend_load = 1'b0;
      end
      redirect = 1'b0;
      reset    = 1'b0;
      ir_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 1) begin
        reset = 1'b1; pend_load = 1'b1; pend_pc = 16'h0000; since = 0;
      end else if (r < 6 || since > 150) begin
        redirect = 1'b1; redirect_pc = 16'($urandom);
        pend_load = 1'b1; pend_pc = redirect_pc; since = 0;
      end else begin
        since++;
      end
    end
    step();
    if (pend_load) load_stream(pend_pc);
    redirect = 1'b0; reset = 1'b0; ir_ready = 1'b0;
    repeat (3) step();
    chk("random_progress", 64'(hs_count - hs0 > 500), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
